// File: rtl/process_monitor_ctrl.sv
// Measurement controller for the process-monitor ring-oscillator macro.
// Runs 2^k captures per request, averages each channel, then scans the
// averages for the minimum enabled channel and the below-threshold alarms.
module process_monitor_ctrl #(
   parameter int unsigned NB_MONITOR   = 14,
   parameter int unsigned COUNT_W      = 16,
   parameter int unsigned TARGET_W     = 16,
   parameter int unsigned AVG_LOG2_MAX = 3,
   parameter int unsigned TIMEOUT_W    = 20,
   localparam int unsigned AVG_W       = (AVG_LOG2_MAX > 0) ? $clog2(AVG_LOG2_MAX + 1) : 1,
   localparam int unsigned IDX_W       = (NB_MONITOR > 1) ? $clog2(NB_MONITOR) : 1
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_start,
   input  logic [TARGET_W-1:0]           i_target,
   input  logic [NB_MONITOR-1:0]         i_use_ro,
   input  logic [AVG_W-1:0]              i_avg_log2,
   input  logic [TIMEOUT_W-1:0]          i_timeout,
   input  logic [COUNT_W-1:0]            i_thresh_lo,
   output logic                          o_pm_enable,
   output logic [TARGET_W-1:0]           o_pm_target,
   output logic [NB_MONITOR-1:0]         o_pm_use_ro,
   input  logic                          i_pm_valid,
   input  logic [NB_MONITOR*COUNT_W-1:0] i_pm_count,
   output logic                          o_busy,
   output logic                          o_done,
   output logic                          o_timeout_err,
   output logic [NB_MONITOR*COUNT_W-1:0] o_result,
   output logic [COUNT_W-1:0]            o_min,
   output logic [IDX_W-1:0]              o_min_idx,
   output logic [NB_MONITOR-1:0]         o_alarm
);

   localparam int unsigned ACC_W = COUNT_W + AVG_LOG2_MAX;
   localparam int unsigned SMP_W = AVG_LOG2_MAX + 1;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_RUN    = 3'd1;
   localparam logic [2:0] S_GAP    = 3'd2;
   localparam logic [2:0] S_REDUCE = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;

   logic [2:0]           state, state_d;
   logic [AVG_W-1:0]     k_r;
   logic [TIMEOUT_W-1:0] tmo_r, tmo_cnt;
   logic [COUNT_W-1:0]   thresh_r;
   logic                 fresh;
   logic [SMP_W-1:0]     samples;
   logic [IDX_W-1:0]     idx;
   logic [ACC_W-1:0]     acc    [NB_MONITOR];
   logic [COUNT_W-1:0]   result [NB_MONITOR];

   logic                 capture_c, last_sample_c, timeout_c, last_idx_c, red_use_c;
   logic [AVG_W-1:0]     k_clamp_c;
   logic [COUNT_W-1:0]   red_val_c;

   // Next-state and per-cycle decode
   always_comb begin
      k_clamp_c     = (i_avg_log2 > AVG_W'(AVG_LOG2_MAX)) ? AVG_W'(AVG_LOG2_MAX) : i_avg_log2;
      capture_c     = (state == S_RUN) && i_pm_valid && fresh;
      last_sample_c = ((samples + SMP_W'(1)) == (SMP_W'(1) << k_r));
      timeout_c     = (state == S_RUN) && !capture_c && (tmo_r != '0) && (tmo_cnt == tmo_r);
      last_idx_c    = (idx == IDX_W'(NB_MONITOR - 1));
      red_use_c     = o_pm_use_ro[idx];
      red_val_c     = COUNT_W'(acc[idx] >> k_r);
      state_d       = state;
      case (state)
         S_IDLE:   if (i_start) state_d = S_RUN;
         S_RUN: begin
            if (capture_c)      state_d = last_sample_c ? S_REDUCE : S_GAP;
            else if (timeout_c) state_d = S_DONE;
         end
         S_GAP:    state_d = S_RUN;
         S_REDUCE: if (last_idx_c) state_d = S_DONE;
         S_DONE:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // State register and state-derived status outputs
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state       <= S_IDLE;
         o_busy      <= 1'b0;
         o_pm_enable <= 1'b0;
         o_done      <= 1'b0;
      end else begin
         state       <= state_d;
         o_busy      <= (state_d != S_IDLE);
         o_pm_enable <= (state_d == S_RUN);
         o_done      <= (state_d == S_DONE);
      end
   end

   // Request latching, accumulation, timeout and the per-channel reduction scan
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_pm_target   <= '0;
         o_pm_use_ro   <= '0;
         o_timeout_err <= 1'b0;
         o_min         <= '0;
         o_min_idx     <= '0;
         o_alarm       <= '0;
         k_r           <= '0;
         tmo_r         <= '0;
         tmo_cnt       <= '0;
         thresh_r      <= '0;
         fresh         <= 1'b0;
         samples       <= '0;
         idx           <= '0;
         for (int unsigned c = 0; c < NB_MONITOR; c++) begin
            acc[c]    <= '0;
            result[c] <= '0;
         end
      end else begin
         case (state)
            S_IDLE: begin
               if (i_start) begin
                  o_pm_target   <= i_target;
                  o_pm_use_ro   <= i_use_ro;
                  k_r           <= k_clamp_c;
                  tmo_r         <= i_timeout;
                  thresh_r      <= i_thresh_lo;
                  o_timeout_err <= 1'b0;
                  fresh         <= 1'b0;
                  samples       <= '0;
                  tmo_cnt       <= TIMEOUT_W'(1);
                  for (int unsigned c = 0; c < NB_MONITOR; c++) acc[c] <= '0;
               end
            end
            S_RUN: begin
               tmo_cnt <= tmo_cnt + TIMEOUT_W'(1);
               if (!i_pm_valid) fresh <= 1'b1;
               if (capture_c) begin
                  for (int unsigned c = 0; c < NB_MONITOR; c++) begin
                     if (o_pm_use_ro[c]) acc[c] <= acc[c] + ACC_W'(i_pm_count[c*COUNT_W +: COUNT_W]);
                  end
                  samples <= samples + SMP_W'(1);
                  if (last_sample_c) begin
                     idx       <= '0;
                     o_min     <= '1;
                     o_min_idx <= '0;
                  end
               end else if (timeout_c) begin
                  o_timeout_err <= 1'b1;
               end
            end
            S_GAP: begin
               fresh   <= 1'b0;
               tmo_cnt <= TIMEOUT_W'(1);
            end
            S_REDUCE: begin
               result[idx]  <= red_use_c ? red_val_c : '0;
               o_alarm[idx] <= red_use_c && (red_val_c < thresh_r);
               if (red_use_c && (red_val_c < o_min)) begin
                  o_min     <= red_val_c;
                  o_min_idx <= idx;
               end
               idx <= idx + IDX_W'(1);
            end
            default: ;
         endcase
      end
   end

   // Flatten the averaged results onto the output bus
   always_comb begin
      o_result = '0;
      for (int unsigned c = 0; c < NB_MONITOR; c++) o_result[c*COUNT_W +: COUNT_W] = result[c];
   end

endmodule
